ntt_coeff_buffer: RTL
=====================

// Module: ntt_coeff_buffer
// PURPOSE
//  Polynomial staging buffer in front of and behind ntt_memory_wrapper. Accepts 2^LOGN coefficients on a
//  valid/ready stream and packs them as lane pairs. Serves the wrapper's read_address and captures its wea
//  writes. Starts and resets the wrapper, then streams the result back out on a valid/ready stream.
// PARAMETERS
//  LOGQ      64  coefficient width
//  LOGN      10  log2 polynomial length N; legal range 4..16
//  AW        max(LOGN,9)+1  wrapper address width (matches wrapper ports)
//  READ_LAT  1   cycles from ntt_raddr to ntt_rdata_*; legal values 1..3
// PORTS
//  clk          in   1     clock
//  rst          in   1     sync active-high reset
//  in_valid     in   1     input coefficient valid
//  in_ready     out  1     buffer accepts coefficient
//  in_data      in   LOGQ  input coefficient, natural index order 0..N-1
//  in_intt      in   1     mode, sampled with coefficient 0
//  ntt_rst      out  1     reset to wrapper
//  ntt_start    out  1     start pulse to wrapper
//  ntt_intt     out  1     latched mode to wrapper
//  ntt_raddr    in   AW    wrapper read_address
//  ntt_rdata_0  out  LOGQ  lane 0 read data
//  ntt_rdata_1  out  LOGQ  lane 1 read data
//  ntt_waddr    in   AW    wrapper write_address
//  ntt_wea      in   1     wrapper write enable
//  ntt_wdata_0  in   LOGQ  lane 0 result
//  ntt_wdata_1  in   LOGQ  lane 1 result
//  ntt_finish   in   1     wrapper finish (level)
//  out_valid    out  1     result coefficient valid
//  out_ready    in   1     downstream ready
//  out_data     out  LOGQ  result coefficient
//  busy         out  1     high in every state other than IDLE
// BEHAVIOUR
//  Storage: two banks IBANK and OBANK, each 2^(LOGN-1) words x 2 lanes.
//   - Word a holds lane0 = coef[a] and lane1 = coef[a+N/2].
//   - Address bits above LOGN-2 are ignored on reads and writes.
//  Reset values: in_ready=0, ntt_rst=1, ntt_start=0, ntt_intt=0, out_valid=0, out_data=0, busy=0,
//   rdata=0. Counters are cleared. Bank contents are not cleared.
//  FSM states and transitions:
//   - IDLE: in_ready=1. The first in_valid handshake latches in_intt, writes coef 0, and moves to LOAD.
//   - LOAD: in_ready=1. Each handshake writes the coefficient at counter i.
//     - i < N/2: written to lane 0 at word i.
//     - otherwise: written to lane 1 at word i-N/2.
//     - The handshake with i = N-1 moves to ARM.
//   - ARM: 1 cycle. in_ready=0 and ntt_rst drops to 0. Moves to RUN.
//   - RUN:
//     - ntt_start=1 in the first RUN cycle only.
//     - Reads: ntt_rdata_* come from IBANK at ntt_raddr, exactly READ_LAT cycles later.
//     - Writes: each ntt_wea cycle writes wdata_0/1 to OBANK at ntt_waddr. The write lands the same cycle.
//     - A rising edge of ntt_finish moves to UNLOAD.
//   - UNLOAD:
//     - out_data = coef[j], in natural order; j counts 0..N-1.
//     - The first valid appears 2 cycles after entering UNLOAD (bank read plus output register).
//     - out_valid/out_data hold while out_ready=0.
//     - The handshake with j = N-1 moves to DRAIN.
//   - DRAIN: 1 cycle. ntt_rst=1, out_valid=0. Moves to IDLE.
//  Ordering: in_ready is 0 in ARM, RUN, UNLOAD and DRAIN, so a new polynomial never overwrites one in flight.
//  Simultaneous events: ntt_wea together with an IBANK read never conflicts, because they are separate banks.
//  ntt_finish outside RUN is ignored.
//  A rst mid-operation returns to IDLE immediately and discards the partial load or unload.
//   ntt_rst=1 on the cycle after rst.
//  ntt_intt is stable from ARM through DRAIN.
// CONFIGURATION
//  NTT_BUF_BITREV_UNLOAD_EN
//   - Defined: UNLOAD emits coef[bitrev_LOGN(j)], so out index j carries the bit-reversed coefficient.
//     Latency and handshake are unchanged.
//   - Undefined: natural order as above.
// TESTING
//  1. LOGN=4, LOGQ=12, load coef[i]=i. -> IBANK word 3 = {lane0=3, lane1=11}; ntt_start pulses once,
//     exactly 2 cycles after the 16th handshake.
//  2. Wrapper model with READ_LAT=1 drives raddr 0..7. -> rdata pair (a, a+8) appears 1 cycle after each
//     address.
//  3. Model writes word k={100+k, 108+k} for k=0..7, then raises finish. -> out_data = 100..115 in order,
//     with 16 handshakes.
//  4. out_ready toggles 1,0,0,1 during UNLOAD. -> out_data is held while stalled; no coefficient is
//     dropped or duplicated.
//  5. rst asserted after 5 loaded coefficients. -> state IDLE, ntt_rst=1, in_ready=1; a fresh
//     16-coefficient load completes normally.
//  6. With NTT_BUF_BITREV_UNLOAD_EN and OBANK holding coef[i]=i. -> out sequence 0,8,4,12,2,10,...,15.

Source files
------------

// File: rtl/ntt_coeff_buffer_if.sv
// Stream and wrapper-side signal bundle for ntt_coeff_buffer.
// The buffer connects through the slave modport; the upstream/wrapper side uses master.
interface ntt_coeff_buffer_if #(
  parameter int LOGQ = 64,
  parameter int AW   = 11
);
  logic            in_valid;
  logic            in_ready;
  logic [LOGQ-1:0] in_data;
  logic            in_intt;
  logic            ntt_rst;
  logic            ntt_start;
  logic            ntt_intt;
  logic [AW-1:0]   ntt_raddr;
  logic [LOGQ-1:0] ntt_rdata_0;
  logic [LOGQ-1:0] ntt_rdata_1;
  logic [AW-1:0]   ntt_waddr;
  logic            ntt_wea;
  logic [LOGQ-1:0] ntt_wdata_0;
  logic [LOGQ-1:0] ntt_wdata_1;
  logic            ntt_finish;
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] out_data;
  logic            busy;

  modport master (
    output in_valid, in_data, in_intt, ntt_raddr, ntt_waddr, ntt_wea,
           ntt_wdata_0, ntt_wdata_1, ntt_finish, out_ready,
    input  in_ready, ntt_rst, ntt_start, ntt_intt, ntt_rdata_0, ntt_rdata_1,
           out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_intt, ntt_raddr, ntt_waddr, ntt_wea,
           ntt_wdata_0, ntt_wdata_1, ntt_finish, out_ready,
    output in_ready, ntt_rst, ntt_start, ntt_intt, ntt_rdata_0, ntt_rdata_1,
           out_valid, out_data, busy
  );
endinterface

// File: rtl/ntt_coeff_buffer.sv
// Lane-pair staging buffer around ntt_memory_wrapper: load, run, unload.
// Optional macro NTT_BUF_BITREV_UNLOAD_EN unloads in bit-reversed coefficient order.
module ntt_coeff_buffer #(
  parameter int LOGQ     = 64,
  parameter int LOGN     = 10,
  parameter int AW       = ((LOGN > 9) ? LOGN : 9) + 1,
  parameter int READ_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  ntt_coeff_buffer_if.slave bus
);

  localparam int N    = 1 << LOGN;
  localparam int HALF = N / 2;
  localparam int WA   = LOGN - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_UNLOAD,
    S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic [LOGQ-1:0] ibank0 [HALF];
  logic [LOGQ-1:0] ibank1 [HALF];
  logic [LOGQ-1:0] obank0 [HALF];
  logic [LOGQ-1:0] obank1 [HALF];

  logic [LOGN-1:0] load_cnt;
  logic            intt_q;
  logic            arm_q;
  logic            finish_q;
  logic [LOGN:0]   rd_cnt;
  logic [LOGN-1:0] rd_idx;
  logic [LOGN-1:0] out_cnt;
  logic            s1_valid;
  logic [LOGQ-1:0] s1_data;
  logic            out_valid_q;
  logic [LOGQ-1:0] out_data_q;
  logic [LOGQ-1:0] rp0 [READ_LAT];
  logic [LOGQ-1:0] rp1 [READ_LAT];

  logic            in_ready_c;
  logic            ntt_rst_c;
  logic            start_c;
  logic            busy_c;
  logic            in_hs;
  logic            out_hs;
  logic            finish_rise;
  logic            out_adv;
  logic            s1_take;
  logic            rd_issue;

  logic [WA-1:0]   raddr_w;
  logic [WA-1:0]   waddr_w;
  logic            unused_addr_bits;

  assign raddr_w          = bus.ntt_raddr[WA-1:0];
  assign waddr_w          = bus.ntt_waddr[WA-1:0];
  assign unused_addr_bits = ^{bus.ntt_raddr[AW-1:WA], bus.ntt_waddr[AW-1:WA]};

  assign in_hs       = bus.in_valid && in_ready_c;
  assign out_hs      = out_valid_q && bus.out_ready;
  assign finish_rise = bus.ntt_finish && !finish_q;

`ifdef NTT_BUF_BITREV_UNLOAD_EN
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
    return r;
  endfunction
  assign rd_idx = bitrev(rd_cnt[LOGN-1:0]);
`else
  assign rd_idx = rd_cnt[LOGN-1:0];
`endif

  // Two-stage unload pipeline (bank read, output register) with back-pressure.
  assign out_adv  = !out_valid_q || bus.out_ready;
  assign s1_take  = s1_valid && out_adv;
  assign rd_issue = (state == S_UNLOAD) && !rd_cnt[LOGN] && (!s1_valid || s1_take);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    ntt_rst_c  = 1'b0;
    start_c    = 1'b0;
    busy_c     = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready_c = !rst;
        ntt_rst_c  = 1'b1;
        busy_c     = 1'b0;
        if (in_hs) state_nx = S_LOAD;
      end
      S_LOAD: begin
        in_ready_c = !rst;
        ntt_rst_c  = 1'b1;
        if (in_hs && (load_cnt == '1)) state_nx = S_ARM;
      end
      S_ARM:  state_nx = S_RUN;
      S_RUN: begin
        start_c = arm_q;
        if (finish_rise) state_nx = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (out_hs && (out_cnt == '1)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        ntt_rst_c = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (rst) ntt_rst_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt    <= '0;
      intt_q      <= 1'b0;
      arm_q       <= 1'b0;
      finish_q    <= 1'b0;
      rd_cnt      <= '0;
      out_cnt     <= '0;
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      arm_q    <= (state == S_ARM);
      finish_q <= bus.ntt_finish;
      // load_cnt wraps back to zero on the final handshake
      if (in_hs) begin
        load_cnt <= load_cnt + 1'b1;
        if (state == S_IDLE) intt_q <= bus.in_intt;
      end
      if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
      if (rd_issue)     s1_valid <= 1'b1;
      else if (s1_take) s1_valid <= 1'b0;
      if (out_adv) begin
        out_valid_q <= s1_valid;
        if (s1_valid) out_data_q <= s1_data;
      end
      if (out_hs) out_cnt <= out_cnt + 1'b1;
      if (state == S_DRAIN) begin
        rd_cnt      <= '0;
        out_cnt     <= '0;
        s1_valid    <= 1'b0;
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      if (load_cnt[LOGN-1]) ibank1[load_cnt[WA-1:0]] <= bus.in_data;
      else                  ibank0[load_cnt[WA-1:0]] <= bus.in_data;
    end
    if ((state == S_RUN) && bus.ntt_wea) begin
      obank0[waddr_w] <= bus.ntt_wdata_0;
      obank1[waddr_w] <= bus.ntt_wdata_1;
    end
    if (rd_issue) s1_data <= rd_idx[LOGN-1] ? obank1[rd_idx[WA-1:0]] : obank0[rd_idx[WA-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < READ_LAT; k++) begin
        rp0[k] <= '0;
        rp1[k] <= '0;
      end
    end else begin
      rp0[0] <= ibank0[raddr_w];
      rp1[0] <= ibank1[raddr_w];
      for (int unsigned k = 1; k < READ_LAT; k++) begin
        rp0[k] <= rp0[k-1];
        rp1[k] <= rp1[k-1];
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.ntt_rst     = ntt_rst_c;
  assign bus.ntt_start   = start_c;
  assign bus.ntt_intt    = intt_q;
  assign bus.ntt_rdata_0 = rp0[READ_LAT-1];
  assign bus.ntt_rdata_1 = rp1[READ_LAT-1];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.busy        = busy_c;

endmodule
